key_conditioner: RTL and testbench
==================================

# key_conditioner

Front-end conditioner for the four DE2 push-buttons feeding the equaliser/menu controller. It synchronises and debounces the raw active-low KEY inputs. It emits single-cycle press pulses on select/back/up/down, with auto-repeat on up/down so held keys step gain and band continuously. It sits directly upstream of the top-level menu FSM, replacing its "after debounce" inputs, and runs in the same BCLK domain.

## Interface
- `DEBOUNCE_CYC`, 20000: consecutive stable cycles required to accept a level change (≥2)
- `REPEAT_DELAY_CYC`, 400000: hold time from accepted press to first repeat pulse (up/down only)
- `REPEAT_PERIOD_CYC`, 100000: interval between subsequent repeat pulses (≥2)
- `i_clk`  in  1  BCLK, the only clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_key_n`  in  4  raw KEY, active-low, asynchronous; [3]=select, [2]=back, [1]=up, [0]=down
- `o_select`  out  1  one-cycle pulse on accepted press
- `o_back`  out  1  one-cycle pulse on accepted press
- `o_up`  out  1  one-cycle pulse on accepted press and each repeat
- `o_down`  out  1  one-cycle pulse on accepted press and each repeat
- `o_held`  out  4  debounced pressed level per key, same bit order as `i_key_n`

## Operation
- Per key: 2-flop synchroniser on `~i_key_n[k]`, then a debounce counter, then a per-key FSM.
- Debounce:
  - Counter increments each cycle the synchronised level differs from the stable level.
  - Counter clears on any cycle it matches.
  - When the counter reaches `DEBOUNCE_CYC` the stable level flips and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYC` cycles never change the stable level.
- FSM states: `K_RELEASED`, `K_PRESSED`, `K_REPEAT`.
  - `K_RELEASED` → `K_PRESSED` on stable 0→1: press pulse, repeat counter cleared.
  - `K_PRESSED` → `K_REPEAT` on repeat counter = `REPEAT_DELAY_CYC`-1 (repeat-enabled keys only): pulse, counter cleared.
  - `K_REPEAT`: pulse each time the counter hits `REPEAT_PERIOD_CYC`-1, counter cleared.
  - Any state → `K_RELEASED` on stable 1→0. No pulse on release.
- Only up and down are repeat-enabled. Select and back stay in `K_PRESSED` until release.
- Up and down both stable-pressed: repeat counters for both are held at 0 and no repeat pulses are emitted. Initial press pulses are still emitted. Repeat timing restarts from 0 for the key still held once the other releases.
- Keys are independent. Simultaneous accepted presses produce simultaneous pulses; no arbitration.
- Counters are saturating-free: widths are `$clog2` of the largest parameter + 1, and they never exceed their terminal values.

## Timing
- Reset: all outputs 0. Synchroniser flops hold "released". Stable levels are released, FSMs are `K_RELEASED`, and all counters are 0.
- Press latency: raw press first sampled at edge t0 (and held) → `o_*` high during exactly the cycle after edge t0+`DEBOUNCE_CYC`+2. Outputs are registered.
- Release latency to `o_held` clear: same, `DEBOUNCE_CYC`+2 edges.
- First repeat pulse: `REPEAT_DELAY_CYC` cycles after the press pulse. Then one pulse every `REPEAT_PERIOD_CYC` cycles.
- Every pulse is exactly 1 cycle wide. Back-to-back pulses on the same output are impossible for legal parameters.
- Reset mid-press: after `i_rst` deasserts with the key still down, the key is treated as a fresh press, giving a pulse `DEBOUNCE_CYC`+2 cycles later.
- Release during the repeat wait: no further pulses. If a repeat terminal count coincides with the release-accept cycle, the release wins and no pulse is emitted.

## Structure
- `key_pkg`: `key_state_t` enum (`K_RELEASED`, `K_PRESSED`, `K_REPEAT`), key index localparams (`KEY_SELECT`=3, `KEY_BACK`=2, `KEY_UP`=1, `KEY_DOWN`=0).
- Sub-module `key_channel`:
  - Contents: synchroniser, debounce counter, FSM and repeat counter.
  - Parameter `REPEAT_EN` plus the three timing parameters.
  - Input `i_repeat_inhibit`, driven by the top for up/down mutual suppression.
- `key_conditioner` instantiates 4 `key_channel`s and the inhibit logic.

## Test plan
Bench parameters for all scenarios: `DEBOUNCE_CYC`=4, `REPEAT_DELAY_CYC`=16, `REPEAT_PERIOD_CYC`=8.
- Clean select press held 10 cycles, then released → `o_select` single pulse at t0+6. `o_held[3]` high from t0+6 until release+6. No repeat.
- Down bouncing (low 2, high 1, low 2, high 1, then steady low) → exactly one `o_down` pulse, 6 cycles after steady low begins. No pulse from glitches.
- Up held 50 cycles → pulses at press P, then P+16, P+24, P+32, P+40. Release stops pulses.
- Up held, then down pressed at P+10 → `o_down` press pulse. No repeats on either while both held. Release down at P+30 → up repeats resume 16 cycles after up's release-accept recomputation begins, i.e. per restart rule.
- Key held, `i_rst` pulsed 1 cycle mid-hold → all outputs 0 the cycle after reset. New press pulse 6 cycles after reset deasserts.
- All four keys pressed same cycle → all four pulses in the same cycle.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and key indices for the DE2 push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        K_RELEASED = 2'd0,
        K_PRESSED  = 2'd1,
        K_REPEAT   = 2'd2
    } key_state_t;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_SELECT = 3;
    localparam int KEY_BACK   = 2;
    localparam int KEY_UP     = 1;
    localparam int KEY_DOWN   = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button lane: 2-flop synchroniser, debounce counter, and the
// press/auto-repeat FSM producing registered one-cycle pulses.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC      = 20000,
    parameter int REPEAT_DELAY_CYC  = 400000,
    parameter int REPEAT_PERIOD_CYC = 100000,
    parameter bit REPEAT_EN         = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_repeat_inhibit,
    output logic o_pulse,
    output logic o_held,
    output logic o_stable
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYC - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_stable;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_pulse;
    logic             r_held;
    logic             w_inhibit;

    assign w_inhibit = i_repeat_inhibit & REPEAT_EN;

    // Stable level only flips after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= 2'b00;
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ~i_key_n};
            if (r_sync[1] == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Release is checked first so it beats a coinciding repeat terminal count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= K_RELEASED;
            r_rep_cnt <= '0;
            r_pulse   <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_held  <= r_stable;
            if (!r_stable) begin
                r_state   <= K_RELEASED;
                r_rep_cnt <= '0;
            end else begin
                case (r_state)
                    K_RELEASED: begin
                        r_state   <= K_PRESSED;
                        r_pulse   <= 1'b1;
                        r_rep_cnt <= '0;
                    end
                    K_PRESSED: begin
                        if (REPEAT_EN) begin
                            if (w_inhibit) begin
                                r_rep_cnt <= '0;
                            end else if (r_rep_cnt == DLY_LAST) begin
                                r_state   <= K_REPEAT;
                                r_pulse   <= 1'b1;
                                r_rep_cnt <= '0;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    K_REPEAT: begin
                        if (w_inhibit) begin
                            r_rep_cnt <= '0;
                        end else if (r_rep_cnt == PER_LAST) begin
                            r_pulse   <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= K_RELEASED;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_pulse  = r_pulse;
    assign o_held   = r_held;
    assign o_stable = r_stable;

endmodule

// File: rtl/key_conditioner.sv
// Four debounced key lanes with up/down auto-repeat and mutual repeat
// suppression while both up and down are held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC      = 20000,
    parameter int REPEAT_DELAY_CYC  = 400000,
    parameter int REPEAT_PERIOD_CYC = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_n,
    output logic       o_select,
    output logic       o_back,
    output logic       o_up,
    output logic       o_down,
    output logic [3:0] o_held
);

    logic [NUM_KEYS-1:0] w_pulse;
    logic [NUM_KEYS-1:0] w_held;
    logic [NUM_KEYS-1:0] w_stable;

    // Each lane is inhibited by its pair partner's stable level (up<->down,
    // select<->back); a pressed lane plus a pressed partner means both held.
    // Select/back ignore the input since they never repeat.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
            .REPEAT_EN         ((k == KEY_UP) || (k == KEY_DOWN))
        ) u_ch (
            .i_clk            (i_clk),
            .i_rst            (i_rst),
            .i_key_n          (i_key_n[k]),
            .i_repeat_inhibit (w_stable[k ^ 1]),
            .o_pulse          (w_pulse[k]),
            .o_held           (w_held[k]),
            .o_stable         (w_stable[k])
        );
    end

    assign o_select = w_pulse[KEY_SELECT];
    assign o_back   = w_pulse[KEY_BACK];
    assign o_up     = w_pulse[KEY_UP];
    assign o_down   = w_pulse[KEY_DOWN];
    assign o_held   = w_held;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int DLY = 16;
    localparam int PER = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic       o_select, o_back, o_up, o_down;
    logic [3:0] o_held;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int q_sel[$], q_back[$], q_up[$], q_down[$];

    key_conditioner #(
        .DEBOUNCE_CYC      (DEB),
        .REPEAT_DELAY_CYC  (DLY),
        .REPEAT_PERIOD_CYC (PER)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_key_n  (key_n),
        .o_select (o_select),
        .o_back   (o_back),
        .o_up     (o_up),
        .o_down   (o_down),
        .o_held   (o_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: cycle index (posedge count) at which each output was seen high.
    always @(negedge clk) begin
        if (o_select) q_sel.push_back(cyc);
        if (o_back)   q_back.push_back(cyc);
        if (o_up)     q_up.push_back(cyc);
        if (o_down)   q_down.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic go_idle();
        key_n = 4'hF;
        repeat (15) @(negedge clk);
        q_sel.delete(); q_back.delete(); q_up.delete(); q_down.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_n = 4'hF;
        repeat (3) @(negedge clk);
        n_chk++;
        if (o_held !== 4'h0) $display("FAIL reset_held: got %h want 0", o_held);
        else n_pass++;
        n_chk++;
        if ({o_select, o_back, o_up, o_down} !== 4'h0)
            $display("FAIL reset_pulses: got %b want 0000", {o_select, o_back, o_up, o_down});
        else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if ({o_held, o_select, o_back, o_up, o_down} !== 8'h00)
            $display("FAIL idle_after_reset: got %h want 00", {o_held, o_select, o_back, o_up, o_down});
        else n_pass++;
    endtask

    task automatic test_select();
        int t0;
        go_idle();
        key_n[3] = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 5);
        n_chk++;
        if (o_held[3] !== 1'b0) $display("FAIL sel_held_early: got %b want 0", o_held[3]);
        else n_pass++;
        wait_until(t0 + 6);
        n_chk++;
        if (o_held[3] !== 1'b1 || o_select !== 1'b1)
            $display("FAIL sel_press: held=%b sel=%b want 1 1", o_held[3], o_select);
        else n_pass++;
        wait_until(t0 + 9);
        key_n[3] = 1'b1;
        wait_until(t0 + 15);
        n_chk++;
        if (o_held[3] !== 1'b1) $display("FAIL sel_held_late: got %b want 1", o_held[3]);
        else n_pass++;
        wait_until(t0 + 16);
        n_chk++;
        if (o_held[3] !== 1'b0) $display("FAIL sel_release: got %b want 0", o_held[3]);
        else n_pass++;
        wait_until(t0 + 40);
        n_chk++;
        if (q_sel.size() != 1 || q_sel[0] != t0 + 6)
            $display("FAIL sel_pulses: got %p want [%0d]", q_sel, t0 + 6);
        else n_pass++;
    endtask

    task automatic test_down_bounce();
        int t0;
        go_idle();
        key_n[0] = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 1); key_n[0] = 1'b1;
        wait_until(t0 + 2); key_n[0] = 1'b0;
        wait_until(t0 + 4); key_n[0] = 1'b1;
        wait_until(t0 + 5); key_n[0] = 1'b0;
        wait_until(t0 + 13); key_n[0] = 1'b1;
        wait_until(t0 + 35);
        n_chk++;
        if (q_down.size() != 1 || q_down[0] != t0 + 12)
            $display("FAIL bounce_down: got %p want [%0d]", q_down, t0 + 12);
        else n_pass++;
        n_chk++;
        if (q_up.size() + q_sel.size() + q_back.size() != 0)
            $display("FAIL bounce_others: got %0d stray pulses want 0", q_up.size() + q_sel.size() + q_back.size());
        else n_pass++;
    endtask

    task automatic test_up_repeat();
        int t0;
        go_idle();
        key_n[1] = 1'b0;
        t0 = cyc + 1;
        // Release accept lands exactly on the would-be repeat at P+48.
        wait_until(t0 + 47); key_n[1] = 1'b1;
        wait_until(t0 + 54);
        n_chk++;
        if (o_up !== 1'b0 || o_held[1] !== 1'b0)
            $display("FAIL up_release_wins: up=%b held=%b want 0 0", o_up, o_held[1]);
        else n_pass++;
        wait_until(t0 + 75);
        n_chk++;
        if (q_up.size() != 5 || q_up[0] != t0 + 6 || q_up[1] != t0 + 22 || q_up[2] != t0 + 30
            || q_up[3] != t0 + 38 || q_up[4] != t0 + 46)
            $display("FAIL up_repeat: got %p want [%0d %0d %0d %0d %0d]", q_up,
                     t0 + 6, t0 + 22, t0 + 30, t0 + 38, t0 + 46);
        else n_pass++;
    endtask

    task automatic test_up_down_inhibit();
        int t0;
        go_idle();
        key_n[1] = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 15); key_n[0] = 1'b0;
        wait_until(t0 + 35); key_n[0] = 1'b1;
        wait_until(t0 + 63); key_n[1] = 1'b1;
        wait_until(t0 + 90);
        n_chk++;
        if (q_up.size() != 3 || q_up[0] != t0 + 6 || q_up[1] != t0 + 57 || q_up[2] != t0 + 65)
            $display("FAIL inhibit_up: got %p want [%0d %0d %0d]", q_up, t0 + 6, t0 + 57, t0 + 65);
        else n_pass++;
        n_chk++;
        if (q_down.size() != 1 || q_down[0] != t0 + 22)
            $display("FAIL inhibit_down: got %p want [%0d]", q_down, t0 + 22);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int t0;
        go_idle();
        key_n[3] = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 10); rst = 1'b1;
        wait_until(t0 + 11);
        n_chk++;
        if ({o_held, o_select, o_back, o_up, o_down} !== 8'h00)
            $display("FAIL midrst_outputs: got %h want 00", {o_held, o_select, o_back, o_up, o_down});
        else n_pass++;
        rst = 1'b0;
        wait_until(t0 + 17);
        n_chk++;
        if (o_select !== 1'b0 || o_held[3] !== 1'b0)
            $display("FAIL midrst_early: sel=%b held=%b want 0 0", o_select, o_held[3]);
        else n_pass++;
        wait_until(t0 + 18);
        n_chk++;
        if (o_select !== 1'b1 || o_held[3] !== 1'b1)
            $display("FAIL midrst_repress: sel=%b held=%b want 1 1", o_select, o_held[3]);
        else n_pass++;
        wait_until(t0 + 20); key_n[3] = 1'b1;
        wait_until(t0 + 35);
        n_chk++;
        if (q_sel.size() != 2 || q_sel[0] != t0 + 6 || q_sel[1] != t0 + 18)
            $display("FAIL midrst_pulses: got %p want [%0d %0d]", q_sel, t0 + 6, t0 + 18);
        else n_pass++;
    endtask

    task automatic test_all_keys();
        int t0;
        go_idle();
        key_n = 4'h0;
        t0 = cyc + 1;
        wait_until(t0 + 6);
        n_chk++;
        if (o_held !== 4'hF) $display("FAIL all_held: got %h want f", o_held);
        else n_pass++;
        n_chk++;
        if ({o_select, o_back, o_up, o_down} !== 4'hF)
            $display("FAIL all_pulses: got %b want 1111", {o_select, o_back, o_up, o_down});
        else n_pass++;
        wait_until(t0 + 9); key_n = 4'hF;
        wait_until(t0 + 30);
        n_chk++;
        if (q_sel.size() != 1 || q_back.size() != 1 || q_up.size() != 1 || q_down.size() != 1
            || q_sel[0] != t0 + 6 || q_back[0] != t0 + 6 || q_up[0] != t0 + 6 || q_down[0] != t0 + 6)
            $display("FAIL all_single: got sel=%p back=%p up=%p down=%p want one each at %0d",
                     q_sel, q_back, q_up, q_down, t0 + 6);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        key_n = 4'hF;
        test_reset();
        test_select();
        test_down_bounce();
        test_up_repeat();
        test_up_down_inhibit();
        test_reset_mid_hold();
        test_all_keys();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
